msrh_l1d_rd_arbiter: RTL

- Shares the single L1D read port (s0 request, s1 response) among REQ_NUM load-side requesters: LSU pipes, LRQ refill check, and the store-request replay path.
- Round-robin arbitration in s0; the granted index is tracked into s1 so each response is steered to its owner.
- A requester that gets a conflict receives priority for one cycle on its retry.
- Sits between the LSU pipelines and the L1D tag/data array, on its master-side read port.

---
 rtl/msrh_l1d_rd_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/msrh_l1d_rd_arbiter.sv
// rtl/msrh_l1d_rd_arbiter.sv - round-robin arbiter sharing the L1D read port among load-side requesters
//
// Purpose:
//   REQ_NUM requesters compete for the single L1D read port. Arbitration is
//   done combinationally in s0. The winner's index is carried into s1 so the
//   L1D response can be steered back to its owner. A requester whose s1
//   access reports a conflict gets priority for exactly one cycle.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_req_valid/paddr     per-requester s0 read requests (paddr flattened, k*PADDR_W)
//   o_req_ready           one-hot grant, same cycle as the request
//   i_s1_kill             per-requester flush of its own s1 access
//   o_l1d_s0_valid/paddr  request to the L1D read port
//   i_l1d_s1_*            s1 result from the L1D
//   o_resp_valid          one-hot s1 response strobe
//   o_resp_hit/miss/conflict/data  broadcast s1 result, qualified by o_resp_valid
//   o_perf_grant_cnt      per-requester 32-bit grant counters (flattened, k*32)
//   o_perf_conflict_cnt   32-bit unkilled-conflict counter
//
// Optional feature: define MSRH_L1D_RD_ARB_PERF_EN to build the performance
// counters. Without it the perf ports are tied to zero and no counter flops exist.

module msrh_l1d_rd_arbiter #(
  parameter int REQ_NUM = 3,
  parameter int PADDR_W = 40,
  parameter int DATA_W  = 64,
  parameter int IDX_W   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [REQ_NUM-1:0]        i_req_valid,
  input  logic [REQ_NUM*PADDR_W-1:0] i_req_paddr,
  output logic [REQ_NUM-1:0]        o_req_ready,
  input  logic [REQ_NUM-1:0]        i_s1_kill,
  output logic                      o_l1d_s0_valid,
  output logic [PADDR_W-1:0]        o_l1d_s0_paddr,
  input  logic                      i_l1d_s1_hit,
  input  logic                      i_l1d_s1_miss,
  input  logic                      i_l1d_s1_conflict,
  input  logic [DATA_W-1:0]         i_l1d_s1_data,
  output logic [REQ_NUM-1:0]        o_resp_valid,
  output logic                      o_resp_hit,
  output logic                      o_resp_miss,
  output logic                      o_resp_conflict,
  output logic [DATA_W-1:0]         o_resp_data,
  output logic [REQ_NUM*32-1:0]     o_perf_grant_cnt,
  output logic [31:0]               o_perf_conflict_cnt
);

  logic [IDX_W-1:0] r_rr_ptr;
  logic             r_s1_valid;
  logic [IDX_W-1:0] r_s1_idx;
  logic             r_retry_valid;
  logic [IDX_W-1:0] r_retry_idx;

  logic             rr_found;
  logic [IDX_W-1:0] rr_idx;
  logic             retry_hit;
  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;
  logic             s1_live;
  logic             s1_killed;
  logic             s1_conflict_ok;

  // Round-robin scan starting at r_rr_ptr with wrap.
  always_comb begin
    int scan;
    rr_found = 1'b0;
    rr_idx   = '0;
    scan     = 0;
    for (int i = 0; i < REQ_NUM; i++) begin
      scan = int'(r_rr_ptr) + i;
      if (scan >= REQ_NUM) scan = scan - REQ_NUM;
      if (!rr_found && i_req_valid[scan]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'(scan);
      end
    end
  end

  // Reset masks the grant so nothing reaches the L1D while held in reset.
  assign retry_hit = !i_reset && r_retry_valid && i_req_valid[r_retry_idx];
  assign grant_any = !i_reset && (retry_hit || rr_found);
  assign grant_idx = retry_hit ? r_retry_idx : rr_idx;

  assign s1_live        = r_s1_valid && !i_reset;
  assign s1_killed      = i_s1_kill[r_s1_idx];
  assign s1_conflict_ok = r_s1_valid && i_l1d_s1_conflict && !s1_killed;

  always_comb begin
    o_req_ready    = '0;
    o_resp_valid   = '0;
    // Index-0 path when idle; the address is don't-care then.
    o_l1d_s0_paddr = i_req_paddr[PADDR_W-1:0];
    for (int k = 0; k < REQ_NUM; k++) begin
      if (grant_any && grant_idx == IDX_W'(k)) begin
        o_req_ready[k] = 1'b1;
        o_l1d_s0_paddr = i_req_paddr[k*PADDR_W +: PADDR_W];
      end
      if (s1_live && r_s1_idx == IDX_W'(k) && !i_s1_kill[k]) begin
        o_resp_valid[k] = 1'b1;
      end
    end
  end

  assign o_l1d_s0_valid  = grant_any;
  assign o_resp_hit      = i_l1d_s1_hit;
  assign o_resp_miss     = i_l1d_s1_miss;
  assign o_resp_conflict = i_l1d_s1_conflict;
  assign o_resp_data     = i_l1d_s1_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rr_ptr      <= '0;
      r_s1_valid    <= 1'b0;
      r_s1_idx      <= '0;
      r_retry_valid <= 1'b0;
      r_retry_idx   <= '0;
    end else begin
      // A retry-priority grant does not disturb the fairness pointer.
      if (grant_any && !retry_hit) begin
        r_rr_ptr <= (grant_idx == IDX_W'(REQ_NUM - 1)) ? '0 : grant_idx + 1'b1;
      end
      r_s1_valid    <= grant_any;
      r_s1_idx      <= grant_idx;
      // Priority lives one cycle only; a killed access never arms it.
      r_retry_valid <= s1_conflict_ok;
      r_retry_idx   <= r_s1_idx;
    end
  end

`ifdef MSRH_L1D_RD_ARB_PERF_EN
  logic [31:0] r_grant_cnt [REQ_NUM];
  logic [31:0] r_conflict_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < REQ_NUM; k++) r_grant_cnt[k] <= '0;
      r_conflict_cnt <= '0;
    end else begin
      for (int k = 0; k < REQ_NUM; k++) begin
        if (i_req_valid[k] && o_req_ready[k]) r_grant_cnt[k] <= r_grant_cnt[k] + 32'd1;
      end
      if (s1_conflict_ok) r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  always_comb begin
    o_perf_grant_cnt = '0;
    for (int k = 0; k < REQ_NUM; k++) o_perf_grant_cnt[k*32 +: 32] = r_grant_cnt[k];
  end
  assign o_perf_conflict_cnt = r_conflict_cnt;
`else
  assign o_perf_grant_cnt    = '0;
  assign o_perf_conflict_cnt = '0;
`endif

endmodule
